// File: rtl/qtcore_mem_pkg.sv
// Shared definitions for the qtcore memory-port arbiter: FSM state codes and
// requester port indices.
package qtcore_mem_pkg;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] RESP   = 2'b10;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // 2'b11 is unused; the FSM falls back to IDLE if it ever appears.
  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_ACCESS = ACCESS,
    ST_RESP   = RESP
  } state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU and debug request ports, the memory macro port and status.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, on contention the port that
// did not win last time wins.
module rr_pick2
  import qtcore_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    if (&req) gnt_idx = ~last;
    else      gnt_idx = req[PORT_DBG];
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug accesses onto the single-port qtcore memory through
// an IDLE -> ACCESS -> RESP sequence with round-robin arbitration.
module mem_port_arbiter
  import qtcore_mem_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  state_t            state_q, state_d;
  logic              last_q;
  logic              owner_q;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              gnt_valid;
  logic              gnt_idx;

  rr_pick2 u_pick (
    .req       ({bus.dbg_req, bus.cpu_req}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_q    <= PORT_DBG;
      owner_q   <= PORT_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state_q <= state_d;
      // Request fields are captured only at grant time.
      if (state_q == ST_IDLE && gnt_valid) begin
        last_q  <= gnt_idx;
        owner_q <= gnt_idx;
        if (gnt_idx == PORT_DBG) begin
          lat_we    <= bus.dbg_we;
          lat_addr  <= bus.dbg_addr;
          lat_wdata <= bus.dbg_wdata;
        end else begin
          lat_we    <= bus.cpu_we;
          lat_addr  <= bus.cpu_addr;
          lat_wdata <= bus.cpu_wdata;
        end
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = gnt_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.cpu_ack   = 1'b0;
    bus.dbg_ack   = 1'b0;
    bus.cpu_rdata = '0;
    bus.dbg_rdata = '0;
    case (state_q)
      ST_ACCESS: begin
        bus.mem_addr  = lat_addr;
        // Gating with rst keeps a reset asserted mid-cycle from committing a write.
        bus.mem_we    = lat_we & rst;
        bus.mem_wdata = lat_wdata;
      end
      ST_RESP: begin
        bus.mem_addr = lat_addr;
        if (owner_q == PORT_DBG) begin
          bus.dbg_ack   = 1'b1;
          bus.dbg_rdata = bus.mem_rdata;
        end else begin
          bus.cpu_ack   = 1'b1;
          bus.cpu_rdata = bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.owner = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level
// timing/memory reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                gap;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous single-port memory stand-in: read data one cycle after address.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  op_t q_cpu[$];
  op_t q_dbg[$];
  op_t cur [2];
  bit  active [2];

  // Reference model: one transaction in flight, granted at g_cyc, ack at g_cyc+2.
  bit                inflight  = 1'b0;
  int                g_cyc     = 0;
  bit                g_port    = 1'b0;
  op_t               g_op;
  int                next_free = 0;
  bit                m_last    = 1'b1;
  bit                m_owner   = 1'b0;
  logic [DATA_W-1:0] mem_ref [DEPTH] = '{default: '0};

  int                log_port[$];
  int                log_cyc[$];
  logic [DATA_W-1:0] log_rdata[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    else n_pass++;
  endtask

  function automatic op_t mk(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input int gap);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d; o.gap = gap;
    return o;
  endfunction

  function automatic bit pending();
    return (q_cpu.size() != 0) || (q_dbg.size() != 0) || active[0] || active[1] || inflight;
  endfunction

  task automatic next_op(input int p);
    op_t h;
    if (p == 0 && q_cpu.size() != 0) begin
      h = q_cpu[0];
      if (h.gap > 0) begin h.gap--; q_cpu[0] = h; end
      else begin cur[0] = q_cpu.pop_front(); active[0] = 1'b1; end
    end else if (p == 1 && q_dbg.size() != 0) begin
      h = q_dbg[0];
      if (h.gap > 0) begin h.gap--; q_dbg[0] = h; end
      else begin cur[1] = q_dbg.pop_front(); active[1] = 1'b1; end
    end
  endtask

  // Request fields of the port being served are scrambled during ACCESS.
  task automatic drive_inputs(input bit acc_now);
    for (int p = 0; p < 2; p++) if (!active[p]) next_op(p);
    bus.cpu_req = active[0];
    bus.dbg_req = active[1];
    if (active[0] && !(acc_now && g_port == 1'b0)) begin
      bus.cpu_we = cur[0].we; bus.cpu_addr = cur[0].addr; bus.cpu_wdata = cur[0].wdata;
    end else begin
      bus.cpu_we = 1'($urandom); bus.cpu_addr = ADDR_W'($urandom); bus.cpu_wdata = DATA_W'($urandom);
    end
    if (active[1] && !(acc_now && g_port == 1'b1)) begin
      bus.dbg_we = cur[1].we; bus.dbg_addr = cur[1].addr; bus.dbg_wdata = cur[1].wdata;
    end else begin
      bus.dbg_we = 1'($urandom); bus.dbg_addr = ADDR_W'($urandom); bus.dbg_wdata = DATA_W'($urandom);
    end
  endtask

  task automatic step();
    bit in_acc, in_rsp, w;
    @(negedge clk);
    cyc++;
    in_acc = inflight && (cyc == g_cyc + 1);
    in_rsp = inflight && (cyc == g_cyc + 2);
    chk("busy",     32'(bus.busy),     32'(in_acc || in_rsp));
    chk("owner",    32'(bus.owner),    32'(m_owner));
    chk("mem_addr", 32'(bus.mem_addr), (in_acc || in_rsp) ? 32'(g_op.addr) : 32'd0);
    chk("mem_we",   32'(bus.mem_we),   32'(in_acc && g_op.we));
    if (!in_rsp) chk("mem_wdata", 32'(bus.mem_wdata), in_acc ? 32'(g_op.wdata) : 32'd0);
    chk("cpu_ack",  32'(bus.cpu_ack),  32'(in_rsp && g_port == 1'b0));
    chk("dbg_ack",  32'(bus.dbg_ack),  32'(in_rsp && g_port == 1'b1));
    if (!(in_rsp && g_port == 1'b0)) chk("cpu_rdata_idle", 32'(bus.cpu_rdata), 32'd0);
    else if (!g_op.we) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(mem_ref[g_op.addr]));
    if (!(in_rsp && g_port == 1'b1)) chk("dbg_rdata_idle", 32'(bus.dbg_rdata), 32'd0);
    else if (!g_op.we) chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(mem_ref[g_op.addr]));
    if (in_rsp) begin
      log_port.push_back(int'(g_port));
      log_cyc.push_back(cyc);
      log_rdata.push_back(g_port ? bus.dbg_rdata : bus.cpu_rdata);
      if (g_op.we) mem_ref[g_op.addr] = g_op.wdata;
      inflight = 1'b0;
      active[g_port] = 1'b0;
    end
    drive_inputs(in_acc);
    if (!inflight && cyc >= next_free && (active[0] || active[1])) begin
      w = (active[0] && active[1]) ? ~m_last : active[1];
      m_last = w; m_owner = w;
      inflight = 1'b1; g_cyc = cyc; g_port = w; g_op = cur[w];
      next_free = cyc + 3;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    active[0] = 1'b0; active[1] = 1'b0;
    q_cpu.delete(); q_dbg.delete();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    #1;
    chk("rst_mem_we_now", 32'(bus.mem_we), 32'd0);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_owner",     32'(bus.owner),     32'd0);
      chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
      chk("rst_dbg_ack",   32'(bus.dbg_ack),   32'd0);
      chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      chk("rst_dbg_rdata", 32'(bus.dbg_rdata), 32'd0);
      chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    end
    rst = 1'b1;
    inflight = 1'b0; m_last = 1'b1; m_owner = 1'b0; next_free = cyc;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (pending() && n < budget) begin step(); n++; end
    if (pending()) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_log();
    log_port.delete(); log_cyc.delete(); log_rdata.delete();
  endtask

  initial begin
    do_reset(2);

    // Contention straight out of reset: CPU must win first, then alternate.
    clear_log();
    q_cpu.push_back(mk(1'b1, 5'h03, 8'h55, 0));
    q_cpu.push_back(mk(1'b0, 5'h0A, 8'h00, 0));
    q_dbg.push_back(mk(1'b1, 5'h0A, 8'h3C, 0));
    q_dbg.push_back(mk(1'b1, 5'h1F, 8'hA5, 0));
    run_idle(100);
    chk("ctn_n", 32'(log_port.size()), 32'd4);
    if (log_port.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("ctn_order", 32'(log_port[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("ctn_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
      chk("ctn_rd_0A", 32'(log_rdata[2]), 32'h3C);
    end

    // Lone CPU read of 0x0A, then read-back of the debug write to 0x1F.
    clear_log();
    q_cpu.push_back(mk(1'b0, 5'h0A, 8'h00, 1));
    run_idle(50);
    q_cpu.push_back(mk(1'b0, 5'h1F, 8'h00, 0));
    run_idle(50);
    chk("single_n", 32'(log_port.size()), 32'd2);
    if (log_port.size() == 2) begin
      chk("single_rd_0A", 32'(log_rdata[0]), 32'h3C);
      chk("rd_1F",        32'(log_rdata[1]), 32'hA5);
    end

    // Held request with a new address right after ack.
    clear_log();
    q_cpu.push_back(mk(1'b0, 5'h03, 8'h00, 0));
    q_cpu.push_back(mk(1'b0, 5'h1F, 8'h00, 0));
    run_idle(50);
    chk("held_n", 32'(log_port.size()), 32'd2);
    if (log_port.size() == 2) begin
      chk("held_rd0",     32'(log_rdata[0]), 32'h55);
      chk("held_rd1",     32'(log_rdata[1]), 32'hA5);
      chk("held_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd3);
    end

    // Reset asserted during the ACCESS cycle of a write must drop it.
    q_dbg.push_back(mk(1'b1, 5'h02, 8'h11, 0));
    run_idle(50);
    q_dbg.push_back(mk(1'b1, 5'h02, 8'h77, 0));
    for (int i = 0; i < 20 && !(inflight && cyc == g_cyc + 1); i++) step();
    chk("mw_reached_access", 32'(inflight && cyc == g_cyc + 1), 32'd1);
    do_reset(2);
    clear_log();
    q_cpu.push_back(mk(1'b0, 5'h02, 8'h00, 0));
    run_idle(50);
    chk("mw_n", 32'(log_port.size()), 32'd1);
    if (log_port.size() == 1) chk("mw_rd_02", 32'(log_rdata[0]), 32'h11);

    // Random traffic from both ports.
    for (int i = 0; i < 150; i++) begin
      q_cpu.push_back(mk(1'($urandom), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom), $urandom_range(0, 3)));
      q_dbg.push_back(mk(1'($urandom), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom), $urandom_range(0, 3)));
    end
    run_idle(5000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the qtcore single-port, 32-byte synchronous memory between the CPU (the fetch/execute path steered by `control_unit`) and the debug/program-load port. Each requester uses a req/ack handshake. The block serialises accesses through a three-state FSM and grants round-robin when both ports contend. It sits between the two requesters and the memory macro, replacing the CPU's direct memory wiring.

## Interface
Parameters:
- `ADDR_W`, default 5: memory address width.
- `DATA_W`, default 8: memory data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data; valid only while `cpu_ack`=1, otherwise 0.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: the same set for the debug port.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after the address is presented.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `owner`  out  1  port index of the current or last grant (0 = CPU, 1 = debug).

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:**
  - No request: stay in IDLE.
  - Any `req` high: pick a winner, latch its `we`/`addr`/`wdata` into internal registers, set `owner`, go to ACCESS.
- **Arbitration:**
  - Only one port requesting: that port wins.
  - Both requesting: the winner is the port ≠ `last` (round-robin).
  - `last` updates to the winner on every grant.
  - `last` resets to 1, so the CPU wins the first contention.
- **ACCESS:**
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - `mem_we` equals the latched `we` AND `rst`; it is high for exactly this one cycle.
  - Always go to RESP.
- **RESP:**
  - `mem_addr` stays at the latched value.
  - `ack` of `owner` is high.
  - `rdata` of `owner` = `mem_rdata` (also driven for writes; the requester ignores it).
  - Always go to IDLE.
- **Requester rule:** the requester drops `req`, or presents a new request, on the edge after its `ack`. A `req` still high in the following IDLE cycle is treated as a new transaction.
- **Request stability:** request fields are sampled only in IDLE. Changes made while `busy` have no effect on the transaction in flight.
- **Idle outputs:** in IDLE, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
- **Reset:** `rst`=0 at an edge forces IDLE, `last`=1, `owner`=0, and clears the latched registers.
  - Reset mid-transaction drops the transaction: no `ack` is issued, and no write occurs during any cycle with `rst`=0.
- **Reset values of outputs:** every output is 0 after reset.

## Timing
- **Latency:** request seen in IDLE at cycle N → ACCESS in N+1 → `ack`/`rdata` in N+2.
- **Throughput:** at most one transaction every 3 cycles. Back-to-back sequence is RESP → IDLE → ACCESS.
- **Fairness:** with both ports continuously requesting, grants alternate CPU, DBG, CPU, …. Each port waits at most 3 extra cycles.
- **Combinational outputs:** `ack`, `rdata`, and the `mem_*` outputs are decoded from registered state. There is no combinational path from any `*_req` input to any output.

## Structure
- **Shared package `qtcore_mem_pkg`:**
  - state localparams IDLE=2'b00, ACCESS=2'b01, RESP=2'b10;
  - port index constants PORT_CPU=0, PORT_DBG=1.
  - Encoding 2'b11 is illegal; the FSM recovers to IDLE on the next edge.
- **Sub-module `rr_pick2`:** purely combinational. Inputs `req[1:0]` and `last`; outputs `gnt_valid` and `gnt_idx`. The `last` register lives in the parent.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles → all outputs 0; first contended grant goes to the CPU.
- **Single CPU read:** `cpu_req`=1, `cpu_we`=0, `cpu_addr`=5'h0A, memory holds 8'h3C → `cpu_ack` exactly once in cycle N+2 with `cpu_rdata`=8'h3C; `dbg_ack` stays 0.
- **Debug write then CPU read:**
  - `dbg` write 8'hA5 to 5'h1F → `mem_we` high for exactly one cycle with `mem_addr`=5'h1F, `mem_wdata`=8'hA5.
  - Subsequent CPU read of 5'h1F → `cpu_rdata`=8'hA5.
- **Contention:** both ports requesting continuously for 4 transactions → ack order CPU, DBG, CPU, DBG, each 3 cycles apart.
- **Reset mid-write:** `rst`=0 during the ACCESS cycle of a write to 5'h02 (memory holds 8'h11) → `mem_we` stays 0, the location still reads 8'h11, no `ack`, FSM in IDLE.
- **Held req:** `cpu_req` kept high after `ack` with a changed address → a second transaction uses the new address; the earlier latched address is not reused.
